// File: rtl/moving_sum_n_if.sv
// Handshake and result bundle for the sliding-window accumulator.
interface moving_sum_n_if #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
);
  localparam int LOG2D = $clog2(DEPTH);
  localparam int SUM_W = WIDTH + LOG2D;

  logic             clr;
  logic             in_valid;
  logic [WIDTH-1:0] in_data;
  logic             in_ready;
  logic             out_valid;
  logic [SUM_W-1:0] out_sum;
  logic [WIDTH-1:0] out_avg;
  logic [LOG2D:0]   out_count;
  logic             out_full;

  modport master (
    output clr, in_valid, in_data,
    input  in_ready, out_valid, out_sum, out_avg, out_count, out_full
  );

  modport slave (
    input  clr, in_valid, in_data,
    output in_ready, out_valid, out_sum, out_avg, out_count, out_full
  );
endinterface

// File: rtl/moving_sum_n.sv
// Running sum of the last DEPTH accepted samples; one add step then one
// evict step per sample, so a new sample is taken at most every 3rd cycle.
module moving_sum_n #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4,
  localparam int LOG2D = $clog2(DEPTH),
  localparam int SUM_W = WIDTH + LOG2D
) (
  input  logic          clk,
  input  logic          rst,
  moving_sum_n_if.slave bus
);
  typedef enum logic [1:0] {IDLE, ADD, SUB} state_t;

  state_t             state_q, state_d;
  logic [SUM_W-1:0]   sum_q, sum_d;
  logic [LOG2D:0]     cnt_q, cnt_d;
  logic [LOG2D-1:0]   ptr_q, ptr_d;
  logic [WIDTH-1:0]   d_q, d_d;
  logic [WIDTH-1:0]   old_q, old_d;
  logic               vld_q, vld_d;
  logic [WIDTH-1:0]   buf_q [DEPTH];

  logic accept;
  assign bus.in_ready = (state_q == IDLE) && !bus.clr;
  assign accept       = bus.in_valid && bus.in_ready;

  always_comb begin
    state_d = state_q;
    sum_d   = sum_q;
    cnt_d   = cnt_q;
    ptr_d   = ptr_q;
    d_d     = d_q;
    old_d   = old_q;
    vld_d   = 1'b0;
    if (bus.clr) begin
      state_d = IDLE;
      sum_d   = '0;
      cnt_d   = '0;
      ptr_d   = '0;
    end else begin
      unique case (state_q)
        IDLE: if (accept) begin
          d_d     = bus.in_data;
          state_d = ADD;
        end
        ADD: begin
          // May overflow SUM_W; the evict step brings it back exactly.
          sum_d   = sum_q + SUM_W'(d_q);
          old_d   = buf_q[ptr_q];
          ptr_d   = (ptr_q == LOG2D'(DEPTH - 1)) ? '0 : ptr_q + 1'b1;
          state_d = SUB;
        end
        SUB: begin
          if (cnt_q == (LOG2D + 1)'(DEPTH)) sum_d = sum_q - SUM_W'(old_q);
          else                              cnt_d = cnt_q + 1'b1;
          vld_d   = 1'b1;
          state_d = IDLE;
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      sum_q   <= '0;
      cnt_q   <= '0;
      ptr_q   <= '0;
      d_q     <= '0;
      old_q   <= '0;
      vld_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      sum_q   <= sum_d;
      cnt_q   <= cnt_d;
      ptr_q   <= ptr_d;
      d_q     <= d_d;
      old_q   <= old_d;
      vld_q   <= vld_d;
    end
  end

  // History contents are don't-care after reset; count gates their use.
  always_ff @(posedge clk) begin
    if (state_q == ADD && !bus.clr) buf_q[ptr_q] <= d_q;
  end

  assign bus.out_valid = vld_q;
  assign bus.out_sum   = sum_q;
  assign bus.out_avg   = sum_q[SUM_W-1:LOG2D];
  assign bus.out_count = cnt_q;
  assign bus.out_full  = (cnt_q == (LOG2D + 1)'(DEPTH));
endmodule

// File: tb/tb_moving_sum_n.sv
// Randomized and directed checks of moving_sum_n against a window-queue model.
module tb_moving_sum_n;
  localparam int WIDTH = 8;
  localparam int DEPTH = 4;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  moving_sum_n_if #(.WIDTH(WIDTH), .DEPTH(DEPTH)) bus ();
  moving_sum_n #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (.clk(clk), .rst(rst), .bus(bus));

  int n_err = 0;
  int n_chk = 0;

  // model: accepted samples still in the window, plus a latency countdown
  int win[$];
  int busy = 0;
  int pend = 0;
  bit exp_vld = 0;

  task automatic chk(input string tag, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, act, exp);
    end
  endtask

  function automatic int win_sum();
    int s = 0;
    foreach (win[i]) s += win[i];
    return s;
  endfunction

  task automatic model_clear();
    win.delete();
    busy = 0;
    exp_vld = 0;
  endtask

  // Caller drives inputs just after a negedge; returns at the next negedge.
  task automatic tick();
    bit rdy, acc, c;
    int d;
    #1;
    rdy = (busy == 0) && !bus.clr;
    chk("in_ready", int'(bus.in_ready), int'(rdy));
    acc = bus.in_valid && rdy;
    c   = bus.clr;
    d   = int'(bus.in_data);
    @(posedge clk);
    exp_vld = 0;
    if (c) model_clear();
    else if (busy > 0) begin
      busy--;
      if (busy == 0) begin
        win.push_back(pend);
        if (win.size() > DEPTH) void'(win.pop_front());
        exp_vld = 1;
      end
    end else if (acc) begin
      busy = 2;
      pend = d;
    end
    @(negedge clk);
    chk("out_valid", int'(bus.out_valid), int'(exp_vld));
    chk("out_count", int'(bus.out_count), win.size());
    chk("out_full", int'(bus.out_full), int'(win.size() == DEPTH));
    if (busy == 0) begin
      chk("out_sum", int'(bus.out_sum), win_sum());
      chk("out_avg", int'(bus.out_avg), win_sum() / DEPTH);
    end
  endtask

  task automatic feed(input int d);
    bus.in_valid = 1'b1;
    bus.in_data  = WIDTH'(d);
    tick();
    bus.in_valid = 1'b0;
    tick();
    tick();
  endtask

  task automatic pulse_clr();
    bus.clr = 1'b1;
    tick();
    bus.clr = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    bus.clr = 1'b0;
    bus.in_valid = 1'b0;
    bus.in_data = '0;
    #1;
    chk("rst_sum", int'(bus.out_sum), 0);
    chk("rst_count", int'(bus.out_count), 0);
    chk("rst_valid", int'(bus.out_valid), 0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    model_clear();

    // fill then slide: 1..6
    for (int i = 1; i <= 6; i++) feed(i);
    chk("seq_sum_final", int'(bus.out_sum), 18);

    // saturating samples exercise the intermediate wrap
    pulse_clr();
    for (int i = 0; i < 5; i++) feed(255);
    chk("max_sum", int'(bus.out_sum), 1020);
    chk("max_avg", int'(bus.out_avg), 255);

    // streaming: in_valid held high
    pulse_clr();
    bus.in_valid = 1'b1;
    bus.in_data  = 8'd8;
    for (int i = 0; i < 12; i++) tick();
    bus.in_valid = 1'b0;
    tick();
    tick();
    chk("stream_sum", int'(bus.out_sum), 32);
    chk("stream_avg", int'(bus.out_avg), 8);

    // clr while the in-flight sample is in its evict step
    pulse_clr();
    for (int i = 1; i <= 4; i++) feed(i);
    bus.in_valid = 1'b1;
    bus.in_data  = 8'd9;
    tick();
    bus.in_valid = 1'b0;
    tick();
    pulse_clr();
    tick();
    tick();
    chk("clr_sum", int'(bus.out_sum), 0);
    feed(7);
    chk("after_clr_sum", int'(bus.out_sum), 7);

    // async reset during the add step
    bus.in_valid = 1'b1;
    bus.in_data  = 8'd5;
    tick();
    bus.in_valid = 1'b0;
    rst = 1'b1;
    #1;
    chk("arst_sum", int'(bus.out_sum), 0);
    chk("arst_count", int'(bus.out_count), 0);
    chk("arst_valid", int'(bus.out_valid), 0);
    model_clear();
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    feed(2);
    feed(2);
    chk("restart_sum", int'(bus.out_sum), 4);

    // clr and in_valid together in IDLE
    bus.clr = 1'b1;
    bus.in_valid = 1'b1;
    bus.in_data = 8'd3;
    tick();
    bus.clr = 1'b0;
    bus.in_valid = 1'b0;
    for (int i = 0; i < 3; i++) tick();

    // random traffic with occasional clears
    for (int i = 0; i < 600; i++) begin
      bus.in_valid = 1'($urandom_range(0, 1));
      bus.in_data  = WIDTH'($urandom);
      bus.clr      = ($urandom_range(0, 29) == 0);
      tick();
    end
    bus.clr = 1'b0;
    bus.in_valid = 1'b0;
    tick();
    tick();
    tick();

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule

// File: doc/moving_sum_n.md
Name: moving_sum_n

Overview:
- Parametrised sliding-window accumulator with its own datapath, history buffer and control FSM.
- Keeps the running sum of the last DEPTH accepted samples. Each sample uses one add step and one subtract step.
- Extends the fixed 3-tap sum/control pair with configurable width and depth, a valid/ready input handshake, fill tracking, synchronous clear and an average output.
- Feeds display and stat logic downstream.

Parameters:
- WIDTH, 8, sample width in bits (unsigned).
- DEPTH, 4, window length. Must be a power of 2 and >= 2.
- LOG2D, $clog2(DEPTH), derived; do not override.
- SUM_W, WIDTH+LOG2D, derived sum width; holds DEPTH*(2^WIDTH-1) exactly.

Ports:
- clk        in   1          clock, rising edge
- rst        in   1          asynchronous reset, active-high
- clr        in   1          synchronous clear of window state
- in_valid   in   1          sample offered
- in_data    in   WIDTH      sample value
- in_ready   out  1          block can accept a sample
- out_valid  out  1          one-cycle pulse: out_sum/out_avg updated for the latest sample
- out_sum    out  SUM_W      running window sum (register)
- out_avg    out  WIDTH      out_sum >> LOG2D (combinational from out_sum)
- out_count  out  LOG2D+1    samples currently in window, 0..DEPTH
- out_full   out  1          out_count == DEPTH

Behaviour:
- Reset (async on rst=1):
  - state=IDLE, out_sum=0, out_count=0, ptr=0, out_valid=0.
  - in_ready=1 once rst deasserts.
  - History buffer contents are don't-care.
- FSM states: IDLE, ADD, SUB.
  - in_ready = (state==IDLE) && !clr.
- IDLE:
  - If in_valid && in_ready at the edge: latch in_data into d_reg, go to ADD. Otherwise stay.
- ADD (one cycle):
  - sum <= sum + d_reg, mod 2^SUM_W.
  - old <= buf[ptr]; buf[ptr] <= d_reg.
  - ptr <= (ptr==DEPTH-1) ? 0 : ptr+1.
  - Go to SUB.
- SUB (one cycle):
  - If count==DEPTH: sum <= sum - old, mod 2^SUM_W.
  - Else: count <= count+1 and sum is unchanged.
  - out_valid <= 1; go to IDLE.
- Timing:
  - out_valid is registered: high for exactly one cycle, starting at the 2nd rising edge after the acceptance edge.
  - The cycle in which out_valid is high is an IDLE cycle, so in_ready=1 there.
  - Max throughput is 1 sample per 3 cycles. Holding in_valid high gives acceptances every 3rd edge.
  - No output backpressure; out_valid is not held.
- Arithmetic:
  - Intermediate sum after ADD may exceed SUM_W (up to (DEPTH+1)*max) and wraps. The value after SUB is exact.
  - out_sum is meaningful only while out_valid=1 or in IDLE.
  - out_avg = floor(sum/DEPTH) even during fill; a partial window counts as zero-padded.
- Fill/wrap:
  - Until out_full, no subtraction is performed.
  - After out_full the oldest sample is evicted each step.
  - ptr wraps DEPTH-1 -> 0.
- clr (sync, any state, priority over everything except rst):
  - Next edge: state=IDLE, sum=0, count=0, ptr=0, out_valid=0.
  - A sample in flight (ADD/SUB) is discarded with no out_valid.
  - in_valid in the same cycle is not accepted.
- rst mid-operation: immediate return to reset values; the in-flight sample is lost.

Test Plan:
- WIDTH=8, DEPTH=4, feed 1,2,3,4,5,6 -> out_sum on each out_valid 1,3,6,10,14,18; out_count 1,2,3,4,4,4; out_full rises on the 4th output.
- Five samples of 255 -> sums 255,510,765,1020,1020. No corruption despite intermediate 1275 wrapping in SUM_W=10. out_avg=255 once full.
- in_valid held high with data 8 -> in_ready pattern 1,0,0 repeating; acceptance every 3 edges; out_valid 2 edges after each acceptance; after 4 samples out_sum=32, out_avg=8.
- After window full (sum 10), assert clr during SUB -> no out_valid; out_sum=0, out_count=0. Next sample 7 -> out_sum=7, out_count=1.
- Assert rst asynchronously mid-ADD -> outputs 0 immediately, not at the next edge; out_valid=0; in_ready=1 after release. Restart with 2,2 -> sums 2,4.
- clr and in_valid both high in IDLE -> sample not accepted (in_ready=0); no out_valid follows.
